fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the synchronous FIFO between `NUM_REQ` producers. It accepts one word per grant, drives the FIFO write port (`wr_en`, `data_in`), and confirms each write from the FIFO's `wr_ack`/`overflow` status. On overflow it retries the same word, so a requester's data is never lost. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 16: FIFO word width; must equal the FIFO's data width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req` in `NUM_REQ`: per-requester write request; held high until granted.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i's word at bits `[i*DATA_WIDTH +: DATA_WIDTH]`; stable while `req[i]` is high.
- `gnt` out `NUM_REQ`: one-hot, one-cycle pulse meaning "word accepted". It is combinational from state and `wr_ack`.
- `wr_en` out 1: FIFO write enable; registered.
- `data_in` out `DATA_WIDTH`: FIFO write data; registered.
- `full` in 1: FIFO full flag.
- `wr_ack` in 1: FIFO write acknowledge; registered by the FIFO one cycle after `wr_en`.
- `overflow` in 1: FIFO overflow flag, with the same timing as `wr_ack`.
- `busy` out 1: high in every state except IDLE.
- `retry_cnt` out 16: number of overflow retries (see Configuration).

## Operation
- **FSM states:** IDLE, WRITE, ACK, HOLD.
- **IDLE:**
  - If any `req` is high and `full` is low, select a winner, latch its index in `owner`, register `data_in`, set `wr_en`, and go to WRITE.
  - If `full` is high, stay in IDLE.
- **Winner selection:** the first requester with `req` high, searching upward from `rr_ptr` modulo `NUM_REQ`.
- **WRITE:** `wr_en` is high for exactly this cycle. Always go to ACK, and clear `wr_en`.
- **ACK:**
  - `wr_ack`=1: `gnt[owner]`=1 in this cycle. Set `rr_ptr` to (`owner`+1) mod `NUM_REQ` and go to IDLE.
  - `overflow`=1, or neither flag set: no grant. Go to HOLD, and increment `retry_cnt` (saturating).
- **HOLD:** wait while `full` is high. When `full` is low, re-register the same `owner`'s data, set `wr_en`, and go to WRITE. The owner is locked; no re-arbitration.
- **Requester rule:** a requester may change `req` or `req_data` only after the edge at which its `gnt` was sampled high. Dropping `req` before grant is illegal. The arbiter does not re-sample `req` outside IDLE.
- `wr_ack` and `overflow` both high in ACK: treat as `wr_ack`.
- Simultaneous requests are resolved by `rr_ptr` only; there is no fixed priority.

## Timing
- **Reset values:** state IDLE, `wr_en`=0, `data_in`=0, `gnt`=0, `busy`=0, `rr_ptr`=0, `owner`=0, `retry_cnt`=0.
- **Reset mid-operation:** outputs clear immediately, asynchronously, and any in-flight word is abandoned. The pending `req` is re-arbitrated after `rst_n` rises.
- **Nominal latency:**
  - Request seen in IDLE at cycle 0.
  - `wr_en` high in cycle 1.
  - `gnt` high in cycle 2.
  - IDLE again in cycle 3.
  - Maximum throughput is one word per 3 cycles.
- At most one `wr_en` is in flight at any time. This guarantees `full` is never stale at issue.

## Configuration
- **Macro:** `FIFO_ARB_STATS_EN`.
- **Defined:** `retry_cnt` is a 16-bit saturating counter, incremented on each ACK→HOLD transition and cleared only by reset.
- **Undefined:** the counter is not built and `retry_cnt` is tied to 0. Retry behaviour is otherwise identical.

## Structure
- **`fifo_shared_pkg`** gains:
  - `arb_state_e` (IDLE/WRITE/ACK/HOLD);
  - `ARB_NUM_REQ` default;
  - `ARB_RETRY_W`=16.
- The existing `FIFO_DEPTH` stays in the package.
- **Sub-module `rr_priority_pick`:** combinational. Inputs are `req` and `rr_ptr`; outputs are `valid` and the winner index. It is instantiated once in IDLE arbitration.

## Test plan
- **Single requester:** FIFO empty, `req`=4'b0100, word 0xA5A5 → `wr_en`=1 with `data_in`=0xA5A5 in cycle 1; `gnt`=4'b0100 in cycle 2; `busy`=0 in cycle 3.
- **Rotation:** all four `req` held high from reset, FIFO never full → grant order 0,1,2,3,0. Exactly one `gnt` bit per grant, grants 3 cycles apart.
- **Full blocking:** `full`=1 for 10 cycles, `req[1]`=1 → `wr_en` stays 0 throughout. `wr_en`=1 one cycle after `full` falls, then `gnt`=4'b0010.
- **Overflow retry:** force `overflow`=1, `wr_ack`=0 in ACK for `req[3]` word 0x1234 → no `gnt`, state HOLD. The same 0x1234 is rewritten; `gnt`=4'b1000 after the successful ack. `retry_cnt`=1 with the macro, 0 without.
- **Reset mid-operation:** `rst_n` low during ACK → `wr_en`, `gnt`, `busy` are 0 immediately and `rr_ptr`=0. After release with `req[2]` still high, the write restarts from IDLE and `gnt`=4'b0100 follows 2 cycles later.

Source files
------------

// File: rtl/fifo_shared_pkg.sv
// -----------------------------------------------------------------------------
// fifo_shared_pkg
// Shared constants and types for the synchronous FIFO and its write-side
// round-robin arbiter.
//   FIFO_DEPTH  : FIFO depth in words
//   arb_state_e : arbiter FSM encoding (idle / write / ack / hold)
//   ARB_NUM_REQ : default number of arbiter requesters
//   ARB_RETRY_W : width of the arbiter overflow-retry counter
// -----------------------------------------------------------------------------
package fifo_shared_pkg;

    localparam int unsigned FIFO_DEPTH  = 16;

    localparam int unsigned ARB_NUM_REQ = 4;
    localparam int unsigned ARB_RETRY_W = 16;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbWrite = 2'd1,
        ArbAck   = 2'd2,
        ArbHold  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// FIFO write-port bundle between the write arbiter and the FIFO.
//   wr_en    : write enable          (master -> slave)
//   data_in  : write data            (master -> slave)
//   full     : FIFO full flag        (slave -> master)
//   wr_ack   : registered write ack  (slave -> master)
//   overflow : registered overflow   (slave -> master)
// master = arbiter side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  wr_ack;
    logic                  overflow;

    modport master (
        output wr_en,
        output data_in,
        input  full,
        input  wr_ack,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  data_in,
        output full,
        output wr_ack,
        output overflow
    );

endinterface

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker: returns the first asserted request found
// searching upward from rr_ptr, wrapping modulo NUM_REQ.
//   req    : request vector
//   rr_ptr : index searched first
//   valid  : at least one request asserted
//   idx    : winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk from farthest to nearest so the nearest hit to rr_ptr wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (32'(rr_ptr) + 32'(i)) % NUM_REQ;
            if (req[IdxW'(j)]) begin
                valid = 1'b1;
                idx   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers.
// One word is written per grant; a write that is not acknowledged (overflow
// or no status) is retried with the same owner and word until it lands.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester write request, held until granted
//   req_data   : packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        : one-hot, one-cycle "word accepted" pulse
//   busy       : high whenever the FSM is not idle
//   retry_cnt  : saturating overflow-retry count
//   fifo       : FIFO write port (wr_en, data_in, full, wr_ack, overflow)
// Build option: FIFO_ARB_STATS_EN builds the retry counter; otherwise
// retry_cnt is tied to zero.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_shared_pkg::*;
#(
    parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic [ARB_RETRY_W-1:0]        retry_cnt,
    fifo_wr_arbiter_if.master             fifo
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    localparam logic [1:0] StIdle  = ArbIdle;
    localparam logic [1:0] StWrite = ArbWrite;
    localparam logic [1:0] StAck   = ArbAck;
    localparam logic [1:0] StHold  = ArbHold;

    logic [1:0]            state_q,   state_d;
    logic [IdxW-1:0]       owner_q,   owner_d;
    logic [IdxW-1:0]       rr_ptr_q,  rr_ptr_d;
    logic                  wr_en_q,   wr_en_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;

    logic                  pick_valid;
    logic [IdxW-1:0]       pick_idx;
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        data_in_d = data_in_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid && !fifo.full) begin
                    owner_d   = pick_idx;
                    data_in_d = req_words[pick_idx];
                    wr_en_d   = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                state_d = StAck;
            end
            StAck: begin
                // wr_ack wins over overflow; anything else is a retry.
                if (fifo.wr_ack) begin
                    rr_ptr_d = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d  = StHold;
                end
            end
            StHold: begin
                // Owner stays locked; no re-arbitration on retry.
                if (!fifo.full) begin
                    data_in_d = req_words[owner_q];
                    wr_en_d   = 1'b1;
                    state_d   = StWrite;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            data_in_q <= data_in_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == StAck && fifo.wr_ack) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign busy         = (state_q != StIdle);
    assign fifo.wr_en   = wr_en_q;
    assign fifo.data_in = data_in_q;

`ifdef FIFO_ARB_STATS_EN
    logic [ARB_RETRY_W-1:0] retry_q, retry_d;

    always_comb begin
        retry_d = retry_q;
        if (state_q == StAck && !fifo.wr_ack && retry_q != '1) begin
            retry_d = retry_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;

`ifdef FIFO_ARB_STATS_EN
    localparam logic [15:0] RetryExp = 16'd1;
`else
    localparam logic [15:0] RetryExp = 16'd0;
`endif

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             busy;
    logic [15:0]      retry_cnt;
    logic             force_ovf;

    int n_vec;
    int n_err;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) fif ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .retry_cnt (retry_cnt),
        .fifo      (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO status model: flags registered one cycle after wr_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fif.wr_ack   <= 1'b0;
            fif.overflow <= 1'b0;
        end else begin
            fif.wr_ack   <= fif.wr_en & ~fif.full & ~force_ovf;
            fif.overflow <= fif.wr_en & (fif.full | force_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        req       = '0;
        req_data  = '0;
        fif.full  = 1'b0;
        force_ovf = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (fif.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", fif.wr_en); end
        n_vec++; if (fif.data_in !== 16'h0) begin n_err++; $display("FAIL reset_data_in: got %h want 0000", fif.data_in); end
        n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (retry_cnt !== 16'h0) begin n_err++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        tick();
        tick();
        n_vec++; if (dut.rr_ptr_q !== 2'd0) begin n_err++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req            = 4'b0100;
        req_data[2*DW +: DW] = 16'hA5A5;
        tick();
        n_vec++; if (fif.wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b want 1", fif.wr_en); end
        n_vec++; if (fif.data_in !== 16'hA5A5) begin n_err++; $display("FAIL single_data: got %h want a5a5", fif.data_in); end
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_early: got %b want 0000", gnt); end
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        n_vec++; if (fif.wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_off: got %b want 0", fif.wr_en); end
        tick();
        req = 4'b0000;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", busy); end
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_after: got %b want 0000", gnt); end
    endtask

    task automatic test_rotation();
        logic [NR-1:0] exp_gnt;
        logic [DW-1:0] exp_word;
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 16'(16'h1000 + i);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt  = 4'b0001 << (k % 4);
            exp_word = 16'(16'h1000 + (k % 4));
            tick();
            n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rot%0d_gnt_wr: got %b want 0000", k, gnt); end
            tick();
            n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rot%0d_gnt: got %b want %b", k, gnt, exp_gnt); end
            n_vec++; if (fif.data_in !== exp_word) begin n_err++; $display("FAIL rot%0d_data: got %h want %h", k, fif.data_in, exp_word); end
            tick();
            if (k == 4) req = 4'b0000;
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rot%0d_idle: got busy %b want 0", k, busy); end
        end
    endtask

    task automatic test_full_block();
        fif.full = 1'b1;
        req      = 4'b0010;
        req_data[1*DW +: DW] = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_vec++; if (fif.wr_en !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL full_block_c%0d: got wr_en %b busy %b want 0 0", c, fif.wr_en, busy);
            end
        end
        fif.full = 1'b0;
        tick();
        n_vec++; if (fif.wr_en !== 1'b1) begin n_err++; $display("FAIL full_release_wr_en: got %b want 1", fif.wr_en); end
        n_vec++; if (fif.data_in !== 16'hBEEF) begin n_err++; $display("FAIL full_release_data: got %h want beef", fif.data_in); end
        tick();
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL full_release_gnt: got %b want 0010", gnt); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_overflow_retry();
        req       = 4'b1000;
        req_data[3*DW +: DW] = 16'h1234;
        force_ovf = 1'b1;
        tick();
        n_vec++; if (fif.wr_en !== 1'b1 || fif.data_in !== 16'h1234) begin
            n_err++; $display("FAIL ovf_first_write: got wr_en %b data %h want 1 1234", fif.wr_en, fif.data_in);
        end
        tick();
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL ovf_no_gnt: got %b want 0000", gnt); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovf_busy: got %b want 1", busy); end
        force_ovf = 1'b0;
        fif.full  = 1'b1;
        tick();
        n_vec++; if (retry_cnt !== RetryExp) begin n_err++; $display("FAIL ovf_retry_cnt: got %0d want %0d", retry_cnt, RetryExp); end
        n_vec++; if (fif.wr_en !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL ovf_hold: got wr_en %b busy %b want 0 1", fif.wr_en, busy);
        end
        tick();
        n_vec++; if (fif.wr_en !== 1'b0) begin n_err++; $display("FAIL ovf_hold_full: got %b want 0", fif.wr_en); end
        fif.full = 1'b0;
        tick();
        n_vec++; if (fif.wr_en !== 1'b1 || fif.data_in !== 16'h1234) begin
            n_err++; $display("FAIL ovf_rewrite: got wr_en %b data %h want 1 1234", fif.wr_en, fif.data_in);
        end
        tick();
        n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL ovf_gnt: got %b want 1000", gnt); end
        tick();
        req = 4'b0000;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        req_data[2*DW +: DW] = 16'h5A5A;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++; if (fif.wr_en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got wr_en %b gnt %b busy %b want 0 0000 0", fif.wr_en, gnt, busy);
        end
        n_vec++; if (dut.rr_ptr_q !== 2'd0) begin n_err++; $display("FAIL rstmid_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
        n_vec++; if (retry_cnt !== 16'h0) begin n_err++; $display("FAIL rstmid_retry: got %0d want 0", retry_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (fif.wr_en !== 1'b1 || fif.data_in !== 16'h5A5A) begin
            n_err++; $display("FAIL rstmid_rewrite: got wr_en %b data %h want 1 5a5a", fif.wr_en, fif.data_in);
        end
        tick();
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL rstmid_gnt: got %b want 0100", gnt); end
        tick();
        req = 4'b0000;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_rotation();
        test_full_block();
        test_overflow_retry();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
